// File: rtl/pc_pkg.sv
// Shared types and constants for the fetch-stage program-counter generator.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package pc_pkg;

    // Kind of control transfer reported by the execute stage
    typedef enum logic [1:0] {
        BR   = 2'd0,
        JAL  = 2'd1,
        JALR = 2'd2,
        RET  = 2'd3
    } redir_type_e;

    // Size of one RV32 instruction in bytes; sequential fetch stride
    localparam int INSTR_BYTES = 4;

endpackage : pc_pkg

// File: rtl/return_addr_stack.sv
// Circular return-address stack with a top pointer and a saturating occupancy count.
// Latency: push/pop take effect on the clock edge they are sampled; top/count are registered.
// Backpressure: none; a push when full overwrites the oldest entry, a pop when empty is ignored.
module return_addr_stack #(
    parameter int XLEN      = 32,
    parameter int RAS_DEPTH = 4,
    localparam int PTR_W    = (RAS_DEPTH > 1) ? $clog2(RAS_DEPTH) : 1,
    localparam int CNT_W    = $clog2(RAS_DEPTH + 1)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic             pop,
    input  logic [XLEN-1:0]  push_data,
    output logic [XLEN-1:0]  top,
    output logic [CNT_W-1:0] count
);

    logic [XLEN-1:0]  mem_q [RAS_DEPTH];
    logic [XLEN-1:0]  mem_d [RAS_DEPTH];
    logic [PTR_W-1:0] ptr_q, ptr_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [PTR_W-1:0] ptr_inc;
    logic [PTR_W-1:0] ptr_dec;
    logic             empty;
    logic             full;

    // Pointer wrap arithmetic that also works for non-power-of-two depths
    always_comb begin
        ptr_inc = (ptr_q == PTR_W'(RAS_DEPTH - 1)) ? '0 : ptr_q + PTR_W'(1);
        ptr_dec = (ptr_q == '0) ? PTR_W'(RAS_DEPTH - 1) : ptr_q - PTR_W'(1);
        empty   = (cnt_q == '0);
        full    = (cnt_q == CNT_W'(RAS_DEPTH));
    end

    // Next-state for pointer, count and storage; push+pop on a live stack rewrites the top in place
    always_comb begin
        ptr_d = ptr_q;
        cnt_d = cnt_q;
        mem_d = mem_q;
        if (push && pop && !empty) begin
            mem_d[ptr_q] = push_data;
        end else if (push) begin
            // Advancing the pointer past the oldest entry when full overwrites it
            ptr_d        = ptr_inc;
            mem_d[ptr_inc] = push_data;
            if (!full) begin
                cnt_d = cnt_q + CNT_W'(1);
            end
        end else if (pop && !empty) begin
            ptr_d = ptr_dec;
            cnt_d = cnt_q - CNT_W'(1);
        end
    end

    // Pointer and count registers; stack contents are meaningless while empty
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ptr_q <= '0;
            cnt_q <= '0;
        end else begin
            ptr_q <= ptr_d;
            cnt_q <= cnt_d;
        end
    end

    // Entry storage needs no reset since count gates every read
    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

    assign top   = mem_q[ptr_q];
    assign count = cnt_q;

endmodule : return_addr_stack

// File: rtl/pc_gen.sv
// Fetch program-counter generator: sequential advance, execute-stage redirects, RAS-predicted returns.
// Latency: 1 cycle from sampled redirect/fetch_ready to new pc; all outputs registered.
// Backpressure: fetch_ready=0 holds pc; a redirect overrides the stall.
module pc_gen
    import pc_pkg::*;
#(
    parameter int              XLEN      = 32,
    parameter logic [XLEN-1:0] RESET_VEC = '0,
    parameter int              RAS_DEPTH = 4,
    localparam int             CNT_W     = $clog2(RAS_DEPTH + 1)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             fetch_ready,
    input  logic             redir_valid,
    input  redir_type_e      redir_type,
    input  logic [XLEN-1:0]  redir_pc,
    input  logic [XLEN-1:0]  redir_imm,
    input  logic [XLEN-1:0]  redir_base,
    input  logic             redir_link,
    output logic [XLEN-1:0]  pc,
    output logic             pc_valid,
    output logic             misalign_err,
    output logic [CNT_W-1:0] ras_count
);

    logic [XLEN-1:0]  pc_q, pc_d;
    logic             pc_valid_q, pc_valid_d;
    logic             misalign_q, misalign_d;

    logic [XLEN-1:0]  ras_top;
    logic [CNT_W-1:0] ras_cnt;
    logic             ras_hit;
    logic             redir_take;
    logic             ras_push;
    logic             ras_pop;
    logic [XLEN-1:0]  link_addr;
    logic [XLEN-1:0]  jalr_tgt;
    logic [XLEN-1:0]  target;

    // Redirect target selection; RET falls back to the JALR formula when nothing is predicted
    always_comb begin
        ras_hit   = (ras_cnt != '0);
        jalr_tgt  = (redir_base + redir_imm) & ~XLEN'(1);
        link_addr = redir_pc + XLEN'(INSTR_BYTES);
        case (redir_type)
            BR, JAL: target = redir_pc + redir_imm;
            JALR:    target = jalr_tgt;
            RET:     target = ras_hit ? ras_top : jalr_tgt;
            default: target = jalr_tgt;
        endcase
    end

    // Stack operations happen only on an accepted redirect; link is meaningless for branches
    always_comb begin
        redir_take = pc_valid_q && redir_valid;
        ras_push   = redir_take && redir_link && (redir_type != BR);
        ras_pop    = redir_take && (redir_type == RET) && ras_hit;
    end

    // PC priority: redirect, then sequential advance, else hold; nothing moves until pc_valid is up
    always_comb begin
        pc_d       = pc_q;
        pc_valid_d = 1'b1;
        misalign_d = 1'b0;
        if (pc_valid_q) begin
            if (redir_valid) begin
                pc_d       = target & ~XLEN'(3);
                misalign_d = target[1];
            end else if (fetch_ready) begin
                pc_d = pc_q + XLEN'(INSTR_BYTES);
            end
        end
    end

    // Output registers with asynchronous return to the reset vector
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pc_q       <= RESET_VEC;
            pc_valid_q <= 1'b0;
            misalign_q <= 1'b0;
        end else begin
            pc_q       <= pc_d;
            pc_valid_q <= pc_valid_d;
            misalign_q <= misalign_d;
        end
    end

    return_addr_stack #(
        .XLEN      (XLEN),
        .RAS_DEPTH (RAS_DEPTH)
    ) u_ras (
        .clk       (clk),
        .reset     (reset),
        .push      (ras_push),
        .pop       (ras_pop),
        .push_data (link_addr),
        .top       (ras_top),
        .count     (ras_cnt)
    );

    assign pc           = pc_q;
    assign pc_valid     = pc_valid_q;
    assign misalign_err = misalign_q;
    assign ras_count    = ras_cnt;

endmodule : pc_gen

// File: tb/tb_pc_gen.sv
// Bench for pc_gen: directed redirects with literal expectations plus a per-cycle reference model.
// Latency: n/a.
// Backpressure: n/a.
module tb_pc_gen;
    import pc_pkg::*;

    localparam int          XLEN      = 32;
    localparam logic [31:0] RESET_VEC = 32'h0000_0000;
    localparam int          RAS_DEPTH = 4;

    logic        clk;
    logic        reset;
    logic        fetch_ready;
    logic        redir_valid;
    redir_type_e redir_type;
    logic [31:0] redir_pc;
    logic [31:0] redir_imm;
    logic [31:0] redir_base;
    logic        redir_link;
    logic [31:0] pc;
    logic        pc_valid;
    logic        misalign_err;
    logic [2:0]  ras_count;

    int n_cmp  = 0;
    int n_fail = 0;

    pc_gen #(
        .XLEN      (XLEN),
        .RESET_VEC (RESET_VEC),
        .RAS_DEPTH (RAS_DEPTH)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .fetch_ready  (fetch_ready),
        .redir_valid  (redir_valid),
        .redir_type   (redir_type),
        .redir_pc     (redir_pc),
        .redir_imm    (redir_imm),
        .redir_base   (redir_base),
        .redir_link   (redir_link),
        .pc           (pc),
        .pc_valid     (pc_valid),
        .misalign_err (misalign_err),
        .ras_count    (ras_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // Reference model: architectural rules with a queue as the return stack
    logic [31:0] m_pc;
    logic        m_vld;
    logic        m_mis;
    logic [31:0] m_tgt;
    logic [31:0] m_ras[$];

    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            m_pc  = RESET_VEC;
            m_vld = 1'b0;
            m_mis = 1'b0;
            m_ras.delete();
        end else if (!m_vld) begin
            m_vld = 1'b1;
            m_mis = 1'b0;
        end else if (redir_valid) begin
            if (redir_type == RET && m_ras.size() > 0) begin
                m_tgt = m_ras.pop_back();
            end else if (redir_type == RET || redir_type == JALR) begin
                m_tgt = (redir_base + redir_imm) & 32'hFFFF_FFFE;
            end else begin
                m_tgt = redir_pc + redir_imm;
            end
            if (redir_link && redir_type != BR) begin
                m_ras.push_back(redir_pc + 32'd4);
                if (m_ras.size() > RAS_DEPTH) void'(m_ras.pop_front());
            end
            m_pc  = m_tgt & 32'hFFFF_FFFC;
            m_mis = m_tgt[1];
        end else begin
            m_mis = 1'b0;
            if (fetch_ready) m_pc = m_pc + 32'd4;
        end
    end

    // Every mid-cycle while out of reset the DUT must agree with the model
    always @(negedge clk) begin
        if (reset) begin
            check("model_pc", pc, m_pc);
            check("model_pc_valid", {31'd0, pc_valid}, {31'd0, m_vld});
            check("model_misalign", {31'd0, misalign_err}, {31'd0, m_mis});
            check("model_ras_count", {29'd0, ras_count}, m_ras.size());
        end
    end

    task automatic redirect(input redir_type_e t, input logic [31:0] rpc, input logic [31:0] imm,
                            input logic [31:0] base, input logic link);
        redir_valid = 1'b1;
        redir_type  = t;
        redir_pc    = rpc;
        redir_imm   = imm;
        redir_base  = base;
        redir_link  = link;
        @(negedge clk);
        redir_valid = 1'b0;
        redir_link  = 1'b0;
    endtask

    initial begin
        logic [31:0] exp_seq [4];
        logic [31:0] exp_ret [4];
        exp_seq = '{32'h0, 32'h4, 32'h8, 32'hC};
        exp_ret = '{32'h54, 32'h44, 32'h34, 32'h24};

        reset       = 1'b0;
        fetch_ready = 1'b0;
        redir_valid = 1'b0;
        redir_type  = BR;
        redir_pc    = '0;
        redir_imm   = '0;
        redir_base  = '0;
        redir_link  = 1'b0;

        // Reset held for three cycles
        repeat (3) @(negedge clk);
        check("reset_pc", pc, RESET_VEC);
        check("reset_pc_valid", {31'd0, pc_valid}, 32'd0);
        check("reset_misalign", {31'd0, misalign_err}, 32'd0);
        check("reset_ras_count", {29'd0, ras_count}, 32'd0);

        // Release with fetch_ready=1 and a redirect that must be ignored on the release edge
        reset       = 1'b1;
        fetch_ready = 1'b1;
        redir_valid = 1'b1;
        redir_type  = JAL;
        redir_pc    = 32'h800;
        redir_imm   = 32'h0;
        redir_link  = 1'b1;
        @(negedge clk);
        redir_valid = 1'b0;
        redir_link  = 1'b0;
        check("release_pc_valid", {31'd0, pc_valid}, 32'd1);
        check("release_ras_ignored", {29'd0, ras_count}, 32'd0);
        for (int i = 0; i < 4; i++) begin
            check($sformatf("seq_pc_%0d", i), pc, exp_seq[i]);
            @(negedge clk);
        end
        check("seq_pc_10", pc, 32'h10);

        // Stall holds, then a branch overrides the stall
        fetch_ready = 1'b0;
        repeat (3) begin
            @(negedge clk);
            check("stall_hold", pc, 32'h10);
        end
        redirect(BR, 32'h08, 32'h20, 32'h0, 1'b0);
        check("br_over_stall", pc, 32'h28);

        // Call and return
        redirect(JAL, 32'h100, 32'h40, 32'h0, 1'b1);
        check("jal_pc", pc, 32'h140);
        check("jal_ras_count", {29'd0, ras_count}, 32'd1);
        redirect(RET, 32'h150, 32'h0, 32'h0, 1'b0);
        check("ret_pc", pc, 32'h104);
        check("ret_ras_count", {29'd0, ras_count}, 32'd0);

        // Overflow: six calls keep the newest four
        for (int i = 0; i < 6; i++) redirect(JAL, 32'(i * 16), 32'h0, 32'h0, 1'b1);
        check("ovf_ras_count", {29'd0, ras_count}, 32'd4);
        for (int i = 0; i < 4; i++) begin
            redirect(RET, 32'h900, 32'h0, 32'h0, 1'b0);
            check($sformatf("ovf_ret_%0d", i), pc, exp_ret[i]);
        end
        check("ovf_ras_empty", {29'd0, ras_count}, 32'd0);
        redirect(RET, 32'h900, 32'h0, 32'h200, 1'b0);
        check("ret_empty_fallback", pc, 32'h200);
        check("ret_empty_count", {29'd0, ras_count}, 32'd0);

        // Misaligned JALR target and address wrap
        redirect(JALR, 32'h40, 32'h0, 32'h103, 1'b0);
        check("misalign_pc", pc, 32'h100);
        check("misalign_set", {31'd0, misalign_err}, 32'd1);
        @(negedge clk);
        check("misalign_clear", {31'd0, misalign_err}, 32'd0);
        redirect(BR, 32'hFFFF_FFF0, 32'h20, 32'h0, 1'b0);
        check("wrap_pc", pc, 32'h10);
        check("wrap_misalign", {31'd0, misalign_err}, 32'd0);

        // Linked JALR and a coroutine return that swaps the top
        redirect(JALR, 32'h600, 32'h11, 32'h1000, 1'b1);
        check("jalr_link_pc", pc, 32'h1010);
        check("jalr_link_count", {29'd0, ras_count}, 32'd1);
        redirect(RET, 32'h500, 32'h0, 32'h0, 1'b1);
        check("corout_pc", pc, 32'h604);
        check("corout_count", {29'd0, ras_count}, 32'd1);
        redirect(RET, 32'h700, 32'h0, 32'h0, 1'b0);
        check("corout_ret_pc", pc, 32'h504);

        // Reach pc=0x40 with two stacked returns, then reset between edges
        redirect(JAL, 32'h0, 32'h40, 32'h0, 1'b1);
        redirect(JAL, 32'h10, 32'h30, 32'h0, 1'b1);
        check("pre_reset_pc", pc, 32'h40);
        check("pre_reset_count", {29'd0, ras_count}, 32'd2);
        #1;
        reset = 1'b0;
        #1;
        check("async_pc", pc, RESET_VEC);
        check("async_pc_valid", {31'd0, pc_valid}, 32'd0);
        check("async_ras_count", {29'd0, ras_count}, 32'd0);
        check("async_no_edge", {31'd0, clk}, 32'd0);
        @(negedge clk);
        reset       = 1'b1;
        fetch_ready = 1'b1;
        repeat (3) @(negedge clk);
        check("post_reset_pc", pc, 32'h8);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule : tb_pc_gen

// File: doc/pc_gen.md
# pc_gen

Parametrised program-counter generator for the fetch stage of the RV32 pipeline. It holds the fetch PC, advances it by one instruction per accepted fetch, and applies branch, jump and return redirects from the execute stage. It keeps a small return-address stack (RAS) so that `RET` redirects have a predicted target. Output is fully registered and drives instruction memory and the IF/ID register.

## Interface
Parameters:
- `XLEN`, 32, address width.
- `RESET_VEC`, 32'h0000_0000, PC value held in reset and the first fetch address.
- `RAS_DEPTH`, 4, return-address stack entries; range 2..16.

Ports:
- `clk`  in  1  single clock, rising edge.
- `reset`  in  1  asynchronous, active-low reset.
- `fetch_ready`  in  1  fetch stage accepts the current `pc` this cycle.
- `redir_valid`  in  1  execute stage redirect request.
- `redir_type`  in  2  `redir_type_e`: BR, JAL, JALR, RET.
- `redir_pc`  in  XLEN  PC of the redirecting instruction.
- `redir_imm`  in  XLEN  sign-extended immediate.
- `redir_base`  in  XLEN  rs1 value for JALR/RET.
- `redir_link`  in  1  push `redir_pc+4` onto the RAS (rd is x1/x5).
- `pc`  out  XLEN  current fetch address.
- `pc_valid`  out  1  `pc` is a valid fetch request.
- `misalign_err`  out  1  one-cycle pulse: last redirect target had `[1]` set.
- `ras_count`  out  $clog2(RAS_DEPTH+1)  occupied RAS entries.

## Operation
- Reset (`reset`=0, asynchronous): `pc`=RESET_VEC, `pc_valid`=0, `misalign_err`=0, `ras_count`=0. RAS contents are don't-care.
- First edge after reset release: `pc_valid`←1 and `pc` stays RESET_VEC. From then on `pc_valid` stays 1.
- Per-edge priority, evaluated only while `pc_valid`=1:
  1. If `redir_valid`: `pc`←target. Redirect overrides a stall.
  2. Else if `fetch_ready`: `pc`←`pc`+4.
  3. Else: hold.
- A redirect arriving in the reset-release cycle (`pc_valid`=0) is ignored.
- Target rules. All arithmetic is modulo 2^XLEN; wrap is silent.
  - BR and JAL: `redir_pc`+`redir_imm`.
  - JALR: (`redir_base`+`redir_imm`) & ~1.
  - RET: RAS top if `ras_count`>0; otherwise the JALR formula.
- Alignment: bits [1:0] of the loaded PC are forced to 0. If target bit [1] was 1, `misalign_err`=1 for the following cycle only.
- RAS, applied only on a redirect edge:
  - Push: `redir_link`=1 with JAL/JALR pushes `redir_pc`+4.
  - Full push: when `ras_count`=RAS_DEPTH, the push overwrites the oldest entry (circular) and the count saturates.
  - Pop: RET pops when nonempty. RET on an empty stack does nothing.
  - RET with `redir_link`=1 (coroutine): the target is read from the old top, then the top is replaced by `redir_pc`+4; the count is unchanged.
  - `redir_link` is ignored for BR.

## Timing
- All outputs are registered. Redirect-to-`pc` latency is 1 cycle; `pc` changes on the edge after `redir_valid` is sampled.
- `ras_count` and RAS contents update on the same edge as `pc`.
- `misalign_err` is asserted in the cycle where the new `pc` first appears.
- No combinational path from any input to any output.
- Reset asserted mid-operation: all outputs return to reset values immediately, with no clock required.

## Structure
- Package `pc_pkg` holds:
  - `typedef enum logic [1:0] {BR, JAL, JALR, RET} redir_type_e`
  - `localparam INSTR_BYTES = 4`
- Sub-module `return_addr_stack`, parameters XLEN and RAS_DEPTH:
  - Circular buffer with a top pointer and a saturating count.
  - Ports: push, pop, push_data, top, count.
  - Uses the same async active-low `reset`.
- `pc_gen` contains the PC register, target mux, priority logic and misalign flag.

## Test plan
- Reset and run: hold `reset`=0 for 3 cycles, release, `fetch_ready`=1 → `pc_valid` rises on the first edge; `pc` sequence 0,0,4,8,C.
- Stall versus redirect: `fetch_ready`=0 at `pc`=0x10 for 3 cycles → `pc` holds 0x10. Then BR with `redir_pc`=0x08, `imm`=0x20 while still stalled → `pc`=0x28 next cycle.
- Calls and returns: JAL `redir_pc`=0x100, `imm`=0x40, `link`=1 → `pc`=0x140, `ras_count`=1. Later RET → `pc`=0x104, `ras_count`=0.
- RAS overflow and underflow with RAS_DEPTH=4: six pushes from `redir_pc`=0x0,0x10,…,0x50 → `ras_count`=4; four RETs yield 0x54, 0x44, 0x34, 0x24. A fifth RET with `base`=0x200, `imm`=0 → `pc`=0x200.
- Misalignment and wrap: JALR `base`=0x103, `imm`=0 → `pc`=0x100, `misalign_err`=1 for one cycle. BR `redir_pc`=0xFFFF_FFF0, `imm`=0x20 → `pc`=0x10.
- Asynchronous reset mid-stream: assert `reset`=0 between edges at `pc`=0x40 with `ras_count`=2 → `pc`=RESET_VEC, `pc_valid`=0 and `ras_count`=0 before the next edge.
